// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared FSM states and TMS sequences for the JTAG master.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_SEQ = 3'd1,
        HEADER  = 3'd2,
        SHIFT   = 3'd3,
        TRAILER = 3'd4,
        FINISH  = 3'd5
    } state_t;

    // TMS sequences, LSB driven first
    localparam logic [5:0] c_rst_tms     = 6'b011111;
    localparam logic [2:0] c_dr_hdr      = 3'b001;
    localparam logic [3:0] c_ir_hdr      = 4'b0011;
    localparam int         c_rst_len     = 6;
    localparam int         c_dr_hdr_len  = 3;
    localparam int         c_ir_hdr_len  = 4;
    localparam int         c_trailer_len = 2;

    function automatic logic [5:0] tms_pattern(input logic tap_reset, input logic is_ir);
        if (tap_reset)
            return c_rst_tms;
        else if (is_ir)
            return {2'b00, c_ir_hdr};
        else
            return {3'b000, c_dr_hdr};
    endfunction

    function automatic int pattern_len(input logic tap_reset, input logic is_ir);
        if (tap_reset)
            return c_rst_len;
        else if (is_ir)
            return c_ir_hdr_len;
        else
            return c_dr_hdr_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_master_if.sv
`default_nettype none
// ============================================================================
// Module      : jtag_master_if
// Description : Command bus plus 4-wire JTAG pins of the JTAG master.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtag_master_if #(
    parameter int MAX_LEN = 22,
    parameter int LEN_W   = 5
);
    logic               start;
    logic               tap_reset;
    logic               is_ir;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] shift_in;
    logic               busy;
    logic               done;
    logic               err;
    logic [MAX_LEN-1:0] shift_out;
    logic               TCK;
    logic               TMS;
    logic               TDI;
    logic               TDO;

    modport master (
        input  start, tap_reset, is_ir, len, shift_in, TDO,
        output busy, done, err, shift_out, TCK, TMS, TDI
    );

    modport slave (
        output start, tap_reset, is_ir, len, shift_in, TDO,
        input  busy, done, err, shift_out, TCK, TMS, TDI
    );
endinterface
`default_nettype wire

// File: rtl/jtag_master_tck_gen.sv
`default_nettype none
// ============================================================================
// Module      : tck_gen
// Description : TCK divider; low phase first, strobes mark the edge-making cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_en,
    output logic      o_tck,
    output logic      o_rise_en,
    output logic      o_fall_en
);
    localparam int                 c_cnt_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tck;
    logic               w_phase_end;

    assign w_phase_end = i_en && (r_cnt == c_cnt_max);
    assign o_rise_en   = w_phase_end && !r_tck;
    assign o_fall_en   = w_phase_end && r_tck;
    assign o_tck       = r_tck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_phase_end) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : jtag_master
// Description : Command-driven JTAG bit-banger: TAP reset, IR scan, DR scan.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_master #(
    parameter int MAX_LEN = 22,
    parameter int LEN_W   = 5,
    parameter int CLK_DIV = 4
) (
    input wire logic      clk,
    input wire logic      reset,
    jtag_master_if.master jtag
);
    import jtag_pkg::*;

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_bit, w_bit_nxt, r_len, w_len_nxt;
    logic               r_is_ir, w_is_ir_nxt, r_err, w_err_nxt;
    logic               r_tms, w_tms_nxt, r_tdi, w_tdi_nxt;
    logic [5:0]         r_pat, w_pat_nxt;
    logic [MAX_LEN-1:0] r_sin, w_sin_nxt, r_sout, w_sout_nxt;
    logic               w_busy, w_tck, w_rise_en, w_fall_en;
    logic               w_len_bad, w_bit_last, w_pat_last;
    logic [LEN_W-1:0]   w_bit_inc, w_len_m1;

    assign w_busy = (r_state == RST_SEQ) || (r_state == HEADER) ||
                    (r_state == SHIFT)   || (r_state == TRAILER);

    tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_busy),
        .o_tck     (w_tck),
        .o_rise_en (w_rise_en),
        .o_fall_en (w_fall_en)
    );

    assign w_len_bad  = (jtag.len == '0) || (32'(jtag.len) > MAX_LEN);
    assign w_bit_inc  = r_bit + 1'b1;
    assign w_len_m1   = r_len - 1'b1;
    assign w_bit_last = (r_bit == w_len_m1);
    assign w_pat_last = (r_bit == LEN_W'(pattern_len(r_state == RST_SEQ, r_is_ir) - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_len_nxt   = r_len;
        w_is_ir_nxt = r_is_ir;
        w_err_nxt   = r_err;
        w_tms_nxt   = r_tms;
        w_tdi_nxt   = r_tdi;
        w_pat_nxt   = r_pat;
        w_sin_nxt   = r_sin;
        w_sout_nxt  = r_sout;

        case (r_state)
            IDLE, FINISH: begin
                w_state_nxt = IDLE;
                if (jtag.start) begin
                    w_bit_nxt = '0;
                    if (!jtag.tap_reset && w_len_bad) begin
                        // rejected scan: done+err next cycle, outputs untouched
                        w_state_nxt = FINISH;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = jtag.tap_reset ? RST_SEQ : HEADER;
                        w_err_nxt   = 1'b0;
                        w_is_ir_nxt = jtag.is_ir;
                        w_len_nxt   = jtag.len;
                        w_sin_nxt   = jtag.shift_in;
                        w_sout_nxt  = '0;
                        w_pat_nxt   = tms_pattern(jtag.tap_reset, jtag.is_ir);
                        w_tms_nxt   = w_pat_nxt[0];
                        w_tdi_nxt   = 1'b0;
                    end
                end
            end
            RST_SEQ, HEADER: begin
                if (w_fall_en) begin
                    if (!w_pat_last) begin
                        w_bit_nxt = w_bit_inc;
                        w_tms_nxt = r_pat[1];
                        w_pat_nxt = r_pat >> 1;
                    end else if (r_state == RST_SEQ) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_state_nxt = SHIFT;
                        w_bit_nxt   = '0;
                        w_tms_nxt   = (w_len_m1 == '0);
                        w_tdi_nxt   = r_sin[0];
                        w_sin_nxt   = r_sin >> 1;
                    end
                end
            end
            SHIFT: begin
                if (w_rise_en) begin
                    w_sout_nxt[r_bit] = jtag.TDO;
                end
                if (w_fall_en) begin
                    if (w_bit_last) begin
                        w_state_nxt = TRAILER;
                        w_bit_nxt   = '0;
                        w_tms_nxt   = 1'b1;
                        w_tdi_nxt   = 1'b0;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tms_nxt = (w_bit_inc == w_len_m1);
                        w_tdi_nxt = r_sin[0];
                        w_sin_nxt = r_sin >> 1;
                    end
                end
            end
            TRAILER: begin
                if (w_fall_en) begin
                    w_tms_nxt = 1'b0;
                    if (r_bit == LEN_W'(c_trailer_len - 1))
                        w_state_nxt = FINISH;
                    else
                        w_bit_nxt = w_bit_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_len   <= '0;
            r_is_ir <= 1'b0;
            r_err   <= 1'b0;
            r_tms   <= 1'b1;
            r_tdi   <= 1'b0;
            r_pat   <= '0;
            r_sin   <= '0;
            r_sout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_len   <= w_len_nxt;
            r_is_ir <= w_is_ir_nxt;
            r_err   <= w_err_nxt;
            r_tms   <= w_tms_nxt;
            r_tdi   <= w_tdi_nxt;
            r_pat   <= w_pat_nxt;
            r_sin   <= w_sin_nxt;
            r_sout  <= w_sout_nxt;
        end
    end

    assign jtag.busy      = w_busy;
    assign jtag.done      = (r_state == FINISH);
    assign jtag.err       = (r_state == FINISH) && r_err;
    assign jtag.shift_out = r_sout;
    assign jtag.TCK       = w_tck;
    assign jtag.TMS       = r_tms;
    assign jtag.TDI       = r_tdi;
endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_master
// Description : Randomized scoreboard bench for jtag_master driving a TAP model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jtag_master;
    localparam int MAX_LEN = 22;
    localparam int LEN_W   = 5;
    localparam int CLK_DIV = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jtag_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) jif ();

    jtag_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .jtag  (jif)
    );

    // ---------------- TAP load: IR 3 bits, 111 = bypass, others = 8-bit reg
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t       tap_st = TLR;
    logic [2:0] tap_ir = 3'b010;
    logic [2:0] ir_sr  = 3'b000;
    logic [7:0] dr8    = 8'h00;
    logic       byp    = 1'b0;
    logic       tdo_r  = 1'bz;
    assign jif.TDO = tdo_r;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:     return tms ? TLR   : RTI;
            RTI:     return tms ? SELDR : RTI;
            SELDR:   return tms ? SELIR : CAPDR;
            CAPDR:   return tms ? EX1DR : SHDR;
            SHDR:    return tms ? EX1DR : SHDR;
            EX1DR:   return tms ? UPDR  : PADR;
            PADR:    return tms ? EX2DR : PADR;
            EX2DR:   return tms ? UPDR  : SHDR;
            UPDR:    return tms ? SELDR : RTI;
            SELIR:   return tms ? TLR   : CAPIR;
            CAPIR:   return tms ? EX1IR : SHIR;
            SHIR:    return tms ? EX1IR : SHIR;
            EX1IR:   return tms ? UPIR  : PAIR;
            PAIR:    return tms ? EX2IR : PAIR;
            EX2IR:   return tms ? UPIR  : SHIR;
            UPIR:    return tms ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge jif.TCK) begin
        case (tap_st)
            TLR:   tap_ir <= 3'b010;
            CAPIR: ir_sr  <= 3'b001;
            SHIR:  ir_sr  <= {jif.TDI, ir_sr[2:1]};
            UPIR:  tap_ir <= ir_sr;
            CAPDR: begin byp <= 1'b0; dr8 <= 8'hA5; end
            SHDR:  if (tap_ir == 3'b111) byp <= jif.TDI; else dr8 <= {jif.TDI, dr8[7:1]};
            default: ;
        endcase
        tap_st <= tap_next(tap_st, jif.TMS);
    end

    always @(negedge jif.TCK)
        tdo_r <= (tap_st == SHIR) ? ir_sr[0] :
                 (tap_st == SHDR) ? ((tap_ir == 3'b111) ? byp : dr8[0]) : 1'bz;

    // ---------------- scoreboard
    typedef struct {
        bit                 err;
        logic [MAX_LEN-1:0] sout;
        int                 ntck;
        logic [63:0]        tms;
        int                 done_cyc;
    } exp_t;
    exp_t sb[$];

    logic [2:0]         model_ir  = 3'b010;
    logic [MAX_LEN-1:0] last_sout = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Scan of a W-bit register: the bit stream seen on TDO is the captured
    // value followed by the data shifted in; the register keeps what remains.
    function automatic void scan_model(input int w, input logic [7:0] cap,
                                       input logic [MAX_LEN-1:0] d, input int l,
                                       output logic [MAX_LEN-1:0] out,
                                       output logic [7:0] nreg);
        bit s[$];
        out  = '0;
        nreg = '0;
        for (int j = 0; j < w; j++) s.push_back(cap[j]);
        for (int j = 0; j < l; j++) s.push_back(d[j]);
        for (int i = 0; i < l; i++) out[i] = s[i];
        for (int k = 0; k < w; k++) nreg[k] = s[l + k];
    endfunction

    // ---------------- monitor
    initial begin
        int          mon_ntck = 0;
        logic [63:0] mon_tms  = '0;
        logic        prev_tck = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_ntck = 0;
                mon_tms  = '0;
                prev_tck = 1'b0;
            end else begin
                if (jif.TCK && !prev_tck) begin
                    mon_tms[mon_ntck] = jif.TMS;
                    mon_ntck++;
                end
                prev_tck = jif.TCK;
                if (jif.done) begin
                    chk("done_expected", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("err",       64'(jif.err),       64'(e.err));
                        chk("shift_out", 64'(jif.shift_out), 64'(e.sout));
                        chk("tck_count", 64'(mon_ntck),      64'(e.ntck));
                        chk("tms_seq",   mon_tms,            e.tms);
                        chk("latency",   64'(cyc),           64'(e.done_cyc));
                        chk("busy_at_done", 64'(jif.busy),   64'd0);
                        if (!e.err) chk("tap_in_rti", 64'(tap_st == RTI), 64'd1);
                    end
                    mon_ntck = 0;
                    mon_tms  = '0;
                end
            end
        end
    end

    // ---------------- stimulus
    task automatic run_cmd(input bit trst, input bit ir, input int len,
                           input logic [MAX_LEN-1:0] din, input bit inject);
        exp_t               e;
        bit                 q[$];
        logic [5:0]         pat;
        int                 plen;
        int                 w;
        int                 k;
        logic [7:0]         cap;
        logic [7:0]         nreg;
        logic [MAX_LEN-1:0] out;

        @(posedge clk); #1;
        jif.start     = 1'b1;
        jif.tap_reset = trst;
        jif.is_ir     = ir;
        jif.len       = LEN_W'(len);
        jif.shift_in  = din;

        e.err = 1'b0;
        if (trst) begin
            pat = 6'b011111;
            for (int i = 0; i < 6; i++) q.push_back(pat[i]);
            model_ir = 3'b010;
            e.sout   = '0;
        end else if (len < 1 || len > MAX_LEN) begin
            e.err  = 1'b1;
            e.sout = last_sout;
        end else begin
            if (ir) begin
                pat = 6'b000011; plen = 4; w = 3; cap = 8'h01;
            end else begin
                pat = 6'b000001; plen = 3;
                if (model_ir == 3'b111) begin w = 1; cap = 8'h00; end
                else begin w = 8; cap = 8'hA5; end
            end
            for (int i = 0; i < plen; i++) q.push_back(pat[i]);
            for (int i = 0; i < len; i++) q.push_back(i == len - 1);
            q.push_back(1'b1);
            q.push_back(1'b0);
            scan_model(w, cap, din, len, out, nreg);
            e.sout = out;
            if (ir) model_ir = nreg[2:0];
        end
        e.ntck = q.size();
        e.tms  = '0;
        for (int i = 0; i < q.size(); i++) e.tms[i] = q[i];
        e.done_cyc = cyc + 1 + 2 * CLK_DIV * e.ntck;
        last_sout  = e.sout;
        sb.push_back(e);

        @(posedge clk); #1;
        jif.start = 1'b0;
        if (inject) begin
            repeat (3) @(posedge clk);
            #1;
            jif.start     = 1'b1;
            jif.tap_reset = 1'b1;
            @(posedge clk); #1;
            jif.start = 1'b0;
        end
        k = 0;
        while (!jif.done && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 2000) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic abort_mid_shift();
        @(posedge clk); #1;
        jif.start     = 1'b1;
        jif.tap_reset = 1'b0;
        jif.is_ir     = 1'b0;
        jif.len       = LEN_W'(20);
        jif.shift_in  = MAX_LEN'($urandom);
        @(posedge clk); #1;
        jif.start = 1'b0;
        repeat (18) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_tck",  64'(jif.TCK),       64'd0);
        chk("abort_tms",  64'(jif.TMS),       64'd1);
        chk("abort_busy", 64'(jif.busy),      64'd0);
        chk("abort_sout", 64'(jif.shift_out), 64'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        last_sout = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int l;
        jif.start     = 1'b0;
        jif.tap_reset = 1'b0;
        jif.is_ir     = 1'b0;
        jif.len       = '0;
        jif.shift_in  = '0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tck",  64'(jif.TCK),       64'd0);
        chk("rst_tms",  64'(jif.TMS),       64'd1);
        chk("rst_tdi",  64'(jif.TDI),       64'd0);
        chk("rst_busy", 64'(jif.busy),      64'd0);
        chk("rst_done", 64'(jif.done),      64'd0);
        chk("rst_err",  64'(jif.err),       64'd0);
        chk("rst_sout", 64'(jif.shift_out), 64'd0);
        reset = 1'b0;

        run_cmd(1'b1, 1'b0, 0, '0, 1'b0);
        run_cmd(1'b0, 1'b1, 3, MAX_LEN'(3'b111), 1'b0);
        run_cmd(1'b0, 1'b0, 4, MAX_LEN'(4'b1011), 1'b0);
        run_cmd(1'b0, 1'b0, 0, MAX_LEN'($urandom), 1'b0);
        run_cmd(1'b0, 1'b0, 23, MAX_LEN'($urandom), 1'b0);
        run_cmd(1'b0, 1'b1, 3, MAX_LEN'(3'b010), 1'b1);
        run_cmd(1'b0, 1'b0, MAX_LEN, MAX_LEN'($urandom), 1'b0);
        run_cmd(1'b0, 1'b0, 1, MAX_LEN'($urandom), 1'b0);
        run_cmd(1'b0, 1'b1, 1, MAX_LEN'($urandom), 1'b0);

        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                run_cmd(1'b1, 1'b0, 0, '0, 1'b0);
            end else if (r == 1) begin
                l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(23, 31);
                run_cmd(1'b0, 1'($urandom_range(0, 1)), l, MAX_LEN'($urandom), 1'b0);
            end else begin
                run_cmd(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, MAX_LEN),
                        MAX_LEN'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        abort_mid_shift();
        run_cmd(1'b1, 1'b0, 0, '0, 1'b0);
        run_cmd(1'b0, 1'b0, 12, MAX_LEN'($urandom), 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
